ball_engine: RTL
================

BALL_ENGINE -- requirements
Module: ball_engine

Interface
REQ-001 Parameter W, default 11: coordinate width in bits.
REQ-002 Parameter O_LEFT, default 390: serve x position (ball left edge).
REQ-003 Parameter O_TOP, default 290: serve y position (ball top edge).
REQ-004 Parameter B_SIZE, default 20: ball width and height in pixels.
REQ-005 Parameters S_WIDTH, default 800, and S_HEIGHT, default 600: screen size.
REQ-006 Parameters X_STEP, default 2, and Y_STEP, default 2: pixels moved per frame step.
REQ-007 Parameter PAD_W, default 10: width of the paddle column at each screen edge.
REQ-008 Parameter SERVE_FRAMES, default 60: frames the ball is held before launch (minimum 1).
REQ-009 PixelClock  in  1: the single clock; all state updates on its rising edge.
REQ-010 Reset  in  1: asynchronous, active-low reset.
REQ-011 FrameTick  in  1: one-cycle pulse per video frame.
REQ-012 Run  in  1: 1 = game advances; 0 = all state frozen.
REQ-013 padLTop, padLBot, padRTop, padRBot  in  W each: left and right paddle vertical extents, top inclusive, bottom exclusive.
REQ-014 xPos, yPos  in  12 each: current raster counters.
REQ-015 drawBall  out  1: raster position lies inside the ball.
REQ-016 ballX, ballY  out  W each: registered ball left and top edges.
REQ-017 scoreL, scoreR  out  1 each: one-cycle point pulses for the left and right player.
REQ-018 hitCount  out  8: paddle returns in the current rally.
REQ-019 state  out  2: SERVE=00, MOVE=01, OUT=10.

Function
REQ-020 The FSM shall have three states: SERVE, MOVE and OUT. Encoding 11 is unreachable and shall recover to SERVE on the next clock.
REQ-021 SERVE: the ball position shall be held at (O_LEFT, O_TOP).
  - Each FrameTick with Run=1 increments the serve counter.
  - On the tick on which the counter reaches SERVE_FRAMES, the counter clears and the FSM enters MOVE.
REQ-022 MOVE: the ball shall update only on a cycle where FrameTick=1 and Run=1; on all other cycles it holds.
REQ-023 Y motion, moving down:
  - If ballY+B_SIZE+Y_STEP >= S_HEIGHT: ballY <= S_HEIGHT-B_SIZE and ydir <= up.
  - Otherwise: ballY <= ballY+Y_STEP.
REQ-024 Y motion, moving up:
  - If ballY <= Y_STEP: ballY <= 0 and ydir <= down.
  - Otherwise: ballY <= ballY-Y_STEP.
REQ-025 X motion, moving right, when ballX+B_SIZE+X_STEP >= S_WIDTH-PAD_W:
  - Right-paddle overlap is (ballY+B_SIZE > padRTop) and (ballY < padRBot), evaluated on the pre-update ballY.
  - If overlap: ballX <= S_WIDTH-PAD_W-B_SIZE, xdir <= left, hitCount increments.
  - If no overlap: FSM enters OUT with scorer = left player.
  - Otherwise (plane not reached): ballX <= ballX+X_STEP.
REQ-026 X motion, moving left, when ballX <= PAD_W+X_STEP:
  - Same overlap test against padLTop and padLBot.
  - If overlap: ballX <= PAD_W, xdir <= right, hitCount increments.
  - If no overlap: FSM enters OUT with scorer = right player.
  - Otherwise: ballX <= ballX-X_STEP.
REQ-027 X and Y updates on the same tick shall be independent; a corner hit applies both bounces in that tick.
REQ-028 hitCount shall saturate at 255 and shall clear on entry to SERVE.
REQ-029 OUT shall last exactly one clock, regardless of Run and FrameTick.
  - The scorer's pulse (scoreL or scoreR) is 1 for that cycle only.
  - Serve xdir is set toward the scorer's side (left scorer -> xdir=left).
  - ydir is unchanged.
  - The FSM then enters SERVE with the position reloaded.
REQ-030 drawBall shall be combinational: 1 iff ballX <= xPos < ballX+B_SIZE and ballY <= yPos < ballY+B_SIZE, compared at 12-bit width with zero extension.
REQ-031 All intermediate sums shall be computed at W+1 bits so that no comparison wraps.

Reset
REQ-032 When Reset=0, the block shall immediately set:
  - state=SERVE, ballX=O_LEFT, ballY=O_TOP, xdir=right, ydir=down;
  - serve counter=0, hitCount=0, scoreL=0, scoreR=0.
REQ-033 Reset asserted mid-rally or during OUT shall suppress any pending score pulse.
  - After deassertion, the first state change occurs only after SERVE_FRAMES ticks.

Verification
REQ-034 Serve timing: defaults, Run=1, FrameTick every 4 clocks -> state=MOVE exactly on the 60th tick; ballX=392 after the 61st tick.
REQ-035 Top wall: ballY=1, ydir=up, one tick -> ballY=0 and ydir=down; the next tick gives ballY=2.
REQ-036 Right paddle hit: ballX=768, ballY=100, xdir=right, padRTop=90, padRBot=150 -> ballX=770, xdir=left, hitCount=1.
REQ-037 Right miss: as REQ-036 but padRTop=300, padRBot=360 -> one-cycle OUT, scoreL=1 for 1 clock, ball at (390,290), xdir=left, hitCount=0.
REQ-038 Freeze and reset: Run=0 for 10 ticks -> ballX and ballY unchanged. Then Reset=0 asynchronously mid-cycle -> outputs at reset values before the next clock edge.
REQ-039 Raster: ball at (100,50), xPos=100, yPos=50 -> drawBall=1; xPos=120 -> drawBall=0; yPos=69 -> drawBall=1.

Source files
------------

// File: rtl/ball_engine.sv
// ball_engine: pong ball position, wall/paddle bounces and serve/score FSM
module ball_engine #(
  parameter int W            = 11,
  parameter int O_LEFT       = 390,
  parameter int O_TOP        = 290,
  parameter int B_SIZE       = 20,
  parameter int S_WIDTH      = 800,
  parameter int S_HEIGHT     = 600,
  parameter int X_STEP       = 2,
  parameter int Y_STEP       = 2,
  parameter int PAD_W        = 10,
  parameter int SERVE_FRAMES = 60
) (
  input  logic         PixelClock,
  input  logic         Reset,
  input  logic         FrameTick,
  input  logic         Run,
  input  logic [W-1:0] padLTop,
  input  logic [W-1:0] padLBot,
  input  logic [W-1:0] padRTop,
  input  logic [W-1:0] padRBot,
  input  logic [11:0]  xPos,
  input  logic [11:0]  yPos,
  output logic         drawBall,
  output logic [W-1:0] ballX,
  output logic [W-1:0] ballY,
  output logic         scoreL,
  output logic         scoreR,
  output logic [7:0]   hitCount,
  output logic [1:0]   state
);
  typedef enum logic [1:0] {SERVE = 2'b00, MOVE = 2'b01, OUT = 2'b10} st_t;
  localparam int WP = W + 1;
  localparam int CW = $clog2(SERVE_FRAMES + 1);
  localparam logic [WP-1:0] BS      = WP'(B_SIZE);
  localparam logic [WP-1:0] XS      = WP'(X_STEP);
  localparam logic [WP-1:0] YS      = WP'(Y_STEP);
  localparam logic [WP-1:0] SH      = WP'(S_HEIGHT);
  localparam logic [WP-1:0] SW_EDGE = WP'(S_WIDTH - PAD_W);
  localparam logic [WP-1:0] X_MIN   = WP'(PAD_W);
  localparam logic [W-1:0]  X0      = W'(O_LEFT);
  localparam logic [W-1:0]  Y0      = W'(O_TOP);
  localparam logic [CW-1:0] SF_LAST = CW'(SERVE_FRAMES - 1);
  localparam logic [11:0]   BS12    = 12'(B_SIZE);
  st_t cur, nxt;
  logic [W-1:0] x_nxt, y_nxt;
  logic [WP-1:0] bx, by;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0] hit_nxt;
  logic xdir, xdir_nxt, ydir, ydir_nxt, left_pt, left_nxt;
  logic step, ovl, down_edge, up_edge, x_edge;
  assign bx        = WP'(ballX);
  assign by        = WP'(ballY);
  assign step      = FrameTick && Run;
  assign down_edge = by + BS + YS >= SH;
  assign up_edge   = by <= YS;
  assign x_edge    = xdir ? (bx + BS + XS >= SW_EDGE) : (bx <= X_MIN + XS);
  assign ovl       = xdir ? (by + BS > WP'(padRTop) && by < WP'(padRBot))
                          : (by + BS > WP'(padLTop) && by < WP'(padLBot));
  assign state     = cur;
  assign scoreL    = cur == OUT && left_pt;
  assign scoreR    = cur == OUT && !left_pt;
  assign drawBall  = xPos >= 12'(ballX) && xPos < 12'(ballX) + BS12 &&
                     yPos >= 12'(ballY) && yPos < 12'(ballY) + BS12;
  always_ff @(posedge PixelClock or negedge Reset)
    if (!Reset) begin
      cur      <= SERVE;
      ballX    <= X0;
      ballY    <= Y0;
      xdir     <= 1'b1;
      ydir     <= 1'b1;
      left_pt  <= 1'b0;
      cnt      <= '0;
      hitCount <= '0;
    end else begin
      cur      <= nxt;
      ballX    <= x_nxt;
      ballY    <= y_nxt;
      xdir     <= xdir_nxt;
      ydir     <= ydir_nxt;
      left_pt  <= left_nxt;
      cnt      <= cnt_nxt;
      hitCount <= hit_nxt;
    end
  always_comb begin
    nxt      = cur;
    x_nxt    = ballX;
    y_nxt    = ballY;
    xdir_nxt = xdir;
    ydir_nxt = ydir;
    left_nxt = left_pt;
    cnt_nxt  = cnt;
    hit_nxt  = hitCount;
    case (cur)
      SERVE: if (step) begin
        cnt_nxt = (cnt == SF_LAST) ? '0 : cnt + 1'b1;
        nxt     = (cnt == SF_LAST) ? MOVE : SERVE;
      end
      MOVE: if (step) begin
        y_nxt    = ydir ? (down_edge ? W'(SH - BS) : W'(by + YS)) : (up_edge ? '0 : W'(by - YS));
        ydir_nxt = ydir ? !down_edge : up_edge;
        if (x_edge && ovl) begin
          x_nxt    = xdir ? W'(SW_EDGE - BS) : W'(X_MIN);
          xdir_nxt = !xdir;
          hit_nxt  = hitCount + {7'd0, hitCount != 8'hff};
        end else if (x_edge) begin
          nxt      = OUT;
          left_nxt = xdir;
        end else
          x_nxt = xdir ? W'(bx + XS) : W'(bx - XS);
      end
      // OUT, and the unreachable encoding, both land in a fresh serve
      default: begin
        nxt      = SERVE;
        x_nxt    = X0;
        y_nxt    = Y0;
        xdir_nxt = (cur == OUT) ? !left_pt : xdir;
        cnt_nxt  = '0;
        hit_nxt  = '0;
      end
    endcase
  end
endmodule
